// File: rtl/bus_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_controller_if
// Description : Ready/valid handshake bundle between the bus controller and
//               the external I/O port pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_controller_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : bus_controller
// Description : Execute-phase data bus sequencer. Selects the register-file
//               save source and runs the external I/O ready/valid handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_controller #(
    parameter logic [2:0] IO_REG    = 3'b110,
    parameter int         TIMEOUT   = 255,
    parameter int         TIMEOUT_W = 8
) (
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         exec_strobe,
    input  wire logic [1:0]   opcode,
    input  wire logic [2:0]   arg0,
    input  wire logic [2:0]   arg1,
    input  wire logic [7:0]   alu_result,
    input  wire logic [7:0]   loadbus,
    bus_controller_if.master  io,
    output logic [7:0]        savebus,
    output logic              save_enable,
    output logic              stall,
    output logic              done,
    output logic [1:0]        error,
    input  wire logic         error_clear
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OUT_WAIT = 2'd1,
        IN_WAIT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [TIMEOUT_W-1:0] C_ONE  = TIMEOUT_W'(1);
    // The abort fires on the edge that would bring the counter up to TIMEOUT.
    localparam logic [TIMEOUT_W-1:0] C_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               r_state, w_state_n;
    logic [TIMEOUT_W-1:0] r_cnt, w_cnt_n;
    logic [7:0]           r_savebus, w_savebus_n;
    logic                 r_save_en, w_save_en_n;
    logic [7:0]           r_out_data, w_out_data_n;
    logic                 r_out_valid, w_out_valid_n;
    logic                 r_in_ready, w_in_ready_n;
    logic [1:0]           r_error, w_error_n;
    logic                 w_expire;

    assign w_expire = (TIMEOUT != 0) && (r_cnt == C_LAST);

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_savebus_n   = r_savebus;
        w_save_en_n   = 1'b0;
        w_out_data_n  = r_out_data;
        w_out_valid_n = r_out_valid;
        w_in_ready_n  = r_in_ready;
        w_error_n     = error_clear ? 2'b00 : r_error;

        if (exec_strobe && (r_state != IDLE)) begin
            w_error_n[1] = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (exec_strobe) begin
                    w_state_n = DONE;
                    case (opcode)
                        2'b01: begin
                            w_savebus_n = alu_result;
                            w_save_en_n = 1'b1;
                        end
                        2'b11: begin
                            // Destination is checked first so IO_REG -> IO_REG is an output.
                            if (arg0 == IO_REG) begin
                                w_out_data_n  = loadbus;
                                w_out_valid_n = 1'b1;
                                w_state_n     = OUT_WAIT;
                            end else if (arg1 == IO_REG) begin
                                w_in_ready_n = 1'b1;
                                w_state_n    = IN_WAIT;
                            end else begin
                                w_savebus_n = loadbus;
                                w_save_en_n = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            OUT_WAIT: begin
                if (r_out_valid && io.out_ready) begin
                    w_out_valid_n = 1'b0;
                    w_cnt_n       = '0;
                    w_state_n     = DONE;
                end else if (w_expire) begin
                    w_out_valid_n = 1'b0;
                    w_error_n[0]  = 1'b1;
                    w_cnt_n       = '0;
                    w_state_n     = DONE;
                end else begin
                    w_cnt_n = r_cnt + C_ONE;
                end
            end
            IN_WAIT: begin
                if (io.in_valid && r_in_ready) begin
                    w_savebus_n  = io.in_data;
                    w_save_en_n  = 1'b1;
                    w_in_ready_n = 1'b0;
                    w_cnt_n      = '0;
                    w_state_n    = DONE;
                end else if (w_expire) begin
                    w_in_ready_n = 1'b0;
                    w_error_n[0] = 1'b1;
                    w_cnt_n      = '0;
                    w_state_n    = DONE;
                end else begin
                    w_cnt_n = r_cnt + C_ONE;
                end
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_savebus   <= '0;
            r_save_en   <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_error     <= 2'b00;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_savebus   <= w_savebus_n;
            r_save_en   <= w_save_en_n;
            r_out_data  <= w_out_data_n;
            r_out_valid <= w_out_valid_n;
            r_in_ready  <= w_in_ready_n;
            r_error     <= w_error_n;
        end
    end

    assign savebus      = r_savebus;
    assign save_enable  = r_save_en;
    assign done         = (r_state == DONE);
    assign stall        = (r_state == OUT_WAIT) || (r_state == IN_WAIT);
    assign error        = r_error;
    assign io.out_data  = r_out_data;
    assign io.out_valid = r_out_valid;
    assign io.in_ready  = r_in_ready;

endmodule
`default_nettype wire

// File: tb/tb_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_controller
// Description : Directed self-checking bench for bus_controller (TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       exec_strobe;
    logic [1:0] opcode;
    logic [2:0] arg0;
    logic [2:0] arg1;
    logic [7:0] alu_result;
    logic [7:0] loadbus;
    logic [7:0] savebus;
    logic       save_enable;
    logic       stall;
    logic       done;
    logic [1:0] error;
    logic       error_clear;

    int tests  = 0;
    int failed = 0;

    bus_controller_if io();

    bus_controller #(
        .IO_REG    (3'b110),
        .TIMEOUT   (4),
        .TIMEOUT_W (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .exec_strobe (exec_strobe),
        .opcode      (opcode),
        .arg0        (arg0),
        .arg1        (arg1),
        .alu_result  (alu_result),
        .loadbus     (loadbus),
        .io          (io),
        .savebus     (savebus),
        .save_enable (save_enable),
        .stall       (stall),
        .done        (done),
        .error       (error),
        .error_clear (error_clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [1:0] op, input logic [2:0] a0, input logic [2:0] a1);
        opcode      = op;
        arg0        = a0;
        arg1        = a1;
        exec_strobe = 1'b1;
        tick();
        exec_strobe = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        exec_strobe  = 1'b0;
        opcode       = 2'b00;
        arg0         = 3'd0;
        arg1         = 3'd0;
        alu_result   = 8'h00;
        loadbus      = 8'h00;
        error_clear  = 1'b0;
        io.in_data   = 8'h00;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_savebus",  savebus,      8'h00);
        chk("rst_save_en",  save_enable,  1'b0);
        chk("rst_done",     done,         1'b0);
        chk("rst_stall",    stall,        1'b0);
        chk("rst_out_val",  io.out_valid, 1'b0);
        chk("rst_in_rdy",   io.in_ready,  1'b0);
        chk("rst_error",    error,        2'b00);

        // ALU save
        alu_result = 8'h5A;
        strobe(2'b01, 3'd0, 3'd0);
        chk("alu_savebus",  savebus,      8'h5A);
        chk("alu_save_en",  save_enable,  1'b1);
        chk("alu_done",     done,         1'b1);
        chk("alu_stall",    stall,        1'b0);
        tick();
        chk("alu_done_off", done,         1'b0);
        chk("alu_se_off",   save_enable,  1'b0);
        chk("alu_hold",     savebus,      8'h5A);

        // Output transfer; handshake lands on the edge the timeout would expire
        loadbus = 8'hC3;
        strobe(2'b11, 3'd6, 3'd0);
        chk("out_valid_c1", io.out_valid, 1'b1);
        chk("out_data_c1",  io.out_data,  8'hC3);
        chk("out_stall_c1", stall,        1'b1);
        loadbus = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("out_valid_w",  io.out_valid, 1'b1);
            chk("out_data_w",   io.out_data,  8'hC3);
            chk("out_stall_w",  stall,        1'b1);
        end
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
        chk("out_done",     done,         1'b1);
        chk("out_save_en",  save_enable,  1'b0);
        chk("out_valid_0",  io.out_valid, 1'b0);
        chk("out_stall_0",  stall,        1'b0);
        chk("out_no_err",   error,        2'b00);
        chk("out_savebus",  savebus,      8'h5A);
        tick();
        chk("out_idle",     done,         1'b0);

        // Input transfer
        strobe(2'b11, 3'd0, 3'd6);
        chk("in_ready_c1",  io.in_ready,  1'b1);
        chk("in_stall_c1",  stall,        1'b1);
        tick();
        tick();
        chk("in_ready_c3",  io.in_ready,  1'b1);
        io.in_valid = 1'b1;
        io.in_data  = 8'h7E;
        tick();
        io.in_valid = 1'b0;
        io.in_data  = 8'h00;
        chk("in_savebus",   savebus,      8'h7E);
        chk("in_save_en",   save_enable,  1'b1);
        chk("in_done",      done,         1'b1);
        chk("in_stall_0",   stall,        1'b0);
        chk("in_ready_0",   io.in_ready,  1'b0);
        tick();
        chk("in_se_off",    save_enable,  1'b0);

        // Timeout: 4 wait cycles then abort
        loadbus = 8'h99;
        strobe(2'b11, 3'd6, 3'd0);
        tick();
        tick();
        tick();
        chk("to_stall_c4",  stall,        1'b1);
        chk("to_err_c4",    error,        2'b00);
        tick();
        chk("to_error",     error,        2'b01);
        chk("to_out_val",   io.out_valid, 1'b0);
        chk("to_save_en",   save_enable,  1'b0);
        chk("to_done",      done,         1'b1);
        tick();
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        chk("to_cleared",   error,        2'b00);

        // Overrun during IN_WAIT, coinciding with error_clear (set wins)
        strobe(2'b11, 3'd0, 3'd6);
        error_clear = 1'b1;
        strobe(2'b01, 3'd0, 3'd0);
        error_clear = 1'b0;
        chk("ovr_error",    error,        2'b10);
        chk("ovr_in_rdy",   io.in_ready,  1'b1);
        chk("ovr_stall",    stall,        1'b1);
        chk("ovr_save_en",  save_enable,  1'b0);

        // Asynchronous reset mid-wait
        #2;
        reset = 1'b1;
        #1;
        chk("arst_in_rdy",  io.in_ready,  1'b0);
        chk("arst_stall",   stall,        1'b0);
        chk("arst_error",   error,        2'b00);
        tick();
        reset = 1'b0;

        // Register copy then NOP
        loadbus = 8'h11;
        strobe(2'b11, 3'd2, 3'd3);
        chk("cp_savebus",   savebus,      8'h11);
        chk("cp_save_en",   save_enable,  1'b1);
        chk("cp_done",      done,         1'b1);
        tick();
        loadbus = 8'h22;
        strobe(2'b00, 3'd2, 3'd3);
        chk("nop_done",     done,         1'b1);
        chk("nop_save_en",  save_enable,  1'b0);
        chk("nop_savebus",  savebus,      8'h11);
        tick();
        strobe(2'b10, 3'd6, 3'd6);
        chk("op10_done",    done,         1'b1);
        chk("op10_stall",   stall,        1'b0);
        tick();

        // Both fields on IO_REG: treated as an output
        loadbus = 8'hA5;
        strobe(2'b11, 3'd6, 3'd6);
        chk("both_out_val", io.out_valid, 1'b1);
        chk("both_in_rdy",  io.in_ready,  1'b0);
        chk("both_data",    io.out_data,  8'hA5);
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
        chk("both_done",    done,         1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
